// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle for the GRF write-back arbiter: pipeline W-stage write, async-unit
// write handshake, scoreboard query and the single GRF write port.
interface grf_wb_arbiter_if;
    logic        p_wen;
    logic [4:0]  p_wadd;
    logic [31:0] p_wdat;
    logic [31:0] p_wpc;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_wadd;
    logic [31:0] a_wdat;
    logic [31:0] a_wpc;
    logic        stall_req;
    logic [4:0]  radd1;
    logic [4:0]  radd2;
    logic        hit1;
    logic        hit2;
    logic        GRFwen;
    logic [4:0]  wadd;
    logic [31:0] wdat;
    logic [31:0] wpc;
    logic        err_drop;

    modport master (
        output p_wen, p_wadd, p_wdat, p_wpc,
        output a_valid, a_wadd, a_wdat, a_wpc,
        output radd1, radd2,
        input  a_ready, stall_req, hit1, hit2,
        input  GRFwen, wadd, wdat, wpc, err_drop
    );

    modport slave (
        input  p_wen, p_wadd, p_wdat, p_wpc,
        input  a_valid, a_wadd, a_wdat, a_wpc,
        input  radd1, radd2,
        output a_ready, stall_req, hit1, hit2,
        output GRFwen, wadd, wdat, wpc, err_drop
    );
endinterface

// File: rtl/grf_wb_arbiter.sv
// GRF write-back arbiter: merges pipeline W-stage writes with buffered async-unit
// writes onto one GRF write port, with starvation stall and hazard scoreboard.
module grf_wb_arbiter (
    input  logic            clk,
    input  logic            rst,
    grf_wb_arbiter_if.slave bus
);
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] wadd;
        logic [DW-1:0] wdat;
        logic [DW-1:0] wpc;
    } entry_t;

    entry_t         mem [DEPTH];
    logic           rptr;
    logic           wptr;
    logic [1:0]     count;
    logic [1:0]     age;
    logic           stall_q;
    logic           err_q;

    logic           nonempty;
    logic           p_req;
    logic           push;
    logic           pop;
    logic           grant_pipe;
    logic           drop;
    logic           age_sat_next;
    logic [DEPTH-1:0] valid;
    entry_t         head;

    assign bus.a_ready   = !rst && (count < 2'(DEPTH));
    assign bus.stall_req = stall_q;
    assign bus.err_drop  = err_q;

    // While stalled the FIFO head owns the port and any pipeline write is lost.
    always_comb begin
        nonempty     = (count != 2'd0);
        p_req        = bus.p_wen && (bus.p_wadd != '0);
        push         = bus.a_valid && bus.a_ready && (bus.a_wadd != '0);
        pop          = !rst && nonempty && (stall_q || !p_req);
        grant_pipe   = !rst && p_req && !stall_q;
        drop         = !rst && p_req && stall_q;
        age_sat_next = nonempty && !pop && (age >= 2'd2);
        head         = mem[rptr];
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid[i] = (count == 2'd2) || ((count == 2'd1) && (rptr == 1'(i)));
        end
    end

    // GRF write port mux; address/data/pc held at zero when idle.
    always_comb begin
        bus.GRFwen = 1'b0;
        bus.wadd   = '0;
        bus.wdat   = '0;
        bus.wpc    = '0;
        if (pop) begin
            bus.GRFwen = 1'b1;
            bus.wadd   = head.wadd;
            bus.wdat   = head.wdat;
            bus.wpc    = head.wpc;
        end else if (grant_pipe) begin
            bus.GRFwen = 1'b1;
            bus.wadd   = bus.p_wadd;
            bus.wdat   = bus.p_wdat;
            bus.wpc    = bus.p_wpc;
        end
    end

    // Scoreboard: pending async writes to a queried register.
    always_comb begin
        bus.hit1 = 1'b0;
        bus.hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && (mem[i].wadd == bus.radd1) && (bus.radd1 != '0)) bus.hit1 = 1'b1;
            if (valid[i] && (mem[i].wadd == bus.radd2) && (bus.radd2 != '0)) bus.hit2 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= '{wadd: bus.a_wadd, wdat: bus.a_wdat, wpc: bus.a_wpc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr    <= 1'b0;
            wptr    <= 1'b0;
            count   <= 2'd0;
            age     <= 2'd0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (pop)  rptr <= ~rptr;
            if (push) wptr <= ~wptr;
            count <= count + 2'(push) - 2'(pop);

            if (pop) begin
                age     <= 2'd0;
                stall_q <= 1'b0;
            end else begin
                if (nonempty && (age != 2'd3)) age <= age + 2'd1;
                if (age_sat_next)              stall_q <= 1'b1;
            end

            if (drop) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_grf_wb_arbiter;
    logic clk = 1'b0;
    logic rst;

    grf_wb_arbiter_if bus ();

    grf_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    int          m_age;
    bit          m_stall;
    bit          m_err;
    bit          m_pop, m_pipe, m_drop, m_push;
    logic        exp_ready, exp_wen, exp_hit1, exp_hit2;
    logic [4:0]  exp_wadd;
    logic [31:0] exp_wdat, exp_wpc;

    int nchecks = 0;
    int nerr    = 0;

    // Reference outputs for the current inputs and model state.
    task automatic model_comb();
        bit preq;
        exp_ready = !rst && (q.size() < 2);
        preq      = bus.p_wen && (bus.p_wadd != 5'd0);
        m_pop     = !rst && (q.size() > 0) && (m_stall || !preq);
        m_pipe    = !rst && preq && !m_stall;
        m_drop    = !rst && preq && m_stall;
        m_push    = exp_ready && bus.a_valid && (bus.a_wadd != 5'd0);
        exp_wen = 1'b0; exp_wadd = '0; exp_wdat = '0; exp_wpc = '0;
        if (m_pop) begin
            exp_wen = 1'b1; exp_wadd = q[0].a; exp_wdat = q[0].d; exp_wpc = q[0].pc;
        end else if (m_pipe) begin
            exp_wen = 1'b1; exp_wadd = bus.p_wadd; exp_wdat = bus.p_wdat; exp_wpc = bus.p_wpc;
        end
        exp_hit1 = 1'b0;
        exp_hit2 = 1'b0;
        foreach (q[i]) begin
            if (bus.radd1 != 5'd0 && q[i].a == bus.radd1) exp_hit1 = 1'b1;
            if (bus.radd2 != 5'd0 && q[i].a == bus.radd2) exp_hit2 = 1'b1;
        end
    endtask

    task automatic model_seq();
        ent_t e;
        bit   had;
        if (rst) begin
            q.delete();
            m_age = 0; m_stall = 0; m_err = 0;
            return;
        end
        had = (q.size() > 0);
        if (m_pop) e = q.pop_front();
        if (m_push) begin
            e.a = bus.a_wadd; e.d = bus.a_wdat; e.pc = bus.a_wpc;
            q.push_back(e);
        end
        if (m_pop) begin
            m_age = 0; m_stall = 0;
        end else if (had) begin
            if (m_age < 3) m_age++;
            if (m_age == 3) m_stall = 1;
        end
        if (m_drop) m_err = 1;
    endtask

    task automatic settle();
        @(negedge clk);
        model_comb();
    endtask

    task automatic advance();
        @(posedge clk);
        model_comb();
        model_seq();
        #1;
    endtask

    task automatic idle_inputs();
        bus.p_wen = 0; bus.p_wadd = '0; bus.p_wdat = '0; bus.p_wpc = '0;
        bus.a_valid = 0; bus.a_wadd = '0; bus.a_wdat = '0; bus.a_wpc = '0;
        bus.radd1 = '0; bus.radd2 = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.p_wen = 1; bus.p_wadd = 5'd4; bus.a_valid = 1; bus.a_wadd = 5'd6;
        settle();
        nchecks++; if (bus.GRFwen !== 1'b0) begin nerr++; $display("FAIL rst_grfwen: got %b want 0", bus.GRFwen); end
        nchecks++; if (bus.a_ready !== 1'b0) begin nerr++; $display("FAIL rst_a_ready: got %b want 0", bus.a_ready); end
        advance();
        advance();
        rst = 1'b0;
        idle_inputs();
        settle();
        nchecks++; if (bus.a_ready !== 1'b1) begin nerr++; $display("FAIL post_rst_a_ready: got %b want 1", bus.a_ready); end
        nchecks++; if (bus.stall_req !== 1'b0) begin nerr++; $display("FAIL post_rst_stall: got %b want 0", bus.stall_req); end
        nchecks++; if (bus.err_drop !== 1'b0) begin nerr++; $display("FAIL post_rst_err: got %b want 0", bus.err_drop); end
        nchecks++; if (bus.GRFwen !== 1'b0 || bus.wadd !== 5'd0) begin nerr++; $display("FAIL post_rst_port: got wen=%b wadd=%0d want 0/0", bus.GRFwen, bus.wadd); end
        advance();
    endtask

    task automatic test_pipe_write();
        idle_inputs();
        bus.p_wen = 1; bus.p_wadd = 5'd5; bus.p_wdat = 32'hA5; bus.p_wpc = 32'h3000;
        settle();
        nchecks++; if (bus.GRFwen !== 1'b1) begin nerr++; $display("FAIL pipe_wen: got %b want 1", bus.GRFwen); end
        nchecks++; if (bus.wadd !== 5'd5 || bus.wdat !== 32'hA5 || bus.wpc !== 32'h3000) begin
            nerr++; $display("FAIL pipe_port: got %0d/%h/%h want 5/a5/3000", bus.wadd, bus.wdat, bus.wpc); end
        advance();
        bus.p_wadd = 5'd0;
        settle();
        nchecks++; if (bus.GRFwen !== 1'b0 || bus.wdat !== 32'd0) begin nerr++; $display("FAIL pipe_r0: got wen=%b wdat=%h want 0/0", bus.GRFwen, bus.wdat); end
        advance();
    endtask

    task automatic test_async_write();
        idle_inputs();
        bus.a_valid = 1; bus.a_wadd = 5'd9; bus.a_wdat = 32'h99; bus.a_wpc = 32'h3010; bus.radd1 = 5'd9;
        settle();
        nchecks++; if (bus.a_ready !== 1'b1) begin nerr++; $display("FAIL async_ready: got %b want 1", bus.a_ready); end
        nchecks++; if (bus.hit1 !== 1'b0) begin nerr++; $display("FAIL async_hit_pre: got %b want 0", bus.hit1); end
        advance();
        bus.a_valid = 0;
        settle();
        nchecks++; if (bus.hit1 !== 1'b1) begin nerr++; $display("FAIL async_hit_pending: got %b want 1", bus.hit1); end
        nchecks++; if (bus.GRFwen !== 1'b1 || bus.wadd !== 5'd9 || bus.wdat !== 32'h99 || bus.wpc !== 32'h3010) begin
            nerr++; $display("FAIL async_write: got wen=%b %0d/%h/%h want 1 9/99/3010", bus.GRFwen, bus.wadd, bus.wdat, bus.wpc); end
        advance();
        settle();
        nchecks++; if (bus.hit1 !== 1'b0 || bus.GRFwen !== 1'b0) begin nerr++; $display("FAIL async_after: got hit=%b wen=%b want 0/0", bus.hit1, bus.GRFwen); end
        advance();
    endtask

    task automatic test_stall();
        idle_inputs();
        bus.a_valid = 1; bus.a_wadd = 5'd7; bus.a_wdat = 32'h77;
        settle();
        advance();
        bus.a_valid = 0;
        bus.p_wen = 1; bus.p_wadd = 5'd1;
        for (int i = 0; i < 3; i++) begin
            bus.p_wdat = 32'(i);
            settle();
            nchecks++; if (bus.wadd !== 5'd1 || bus.stall_req !== 1'b0) begin
                nerr++; $display("FAIL stall_wait%0d: got wadd=%0d stall=%b want 1/0", i, bus.wadd, bus.stall_req); end
            advance();
        end
        bus.p_wen = 0;
        settle();
        nchecks++; if (bus.stall_req !== 1'b1) begin nerr++; $display("FAIL stall_set: got %b want 1", bus.stall_req); end
        nchecks++; if (bus.GRFwen !== 1'b1 || bus.wadd !== 5'd7) begin nerr++; $display("FAIL stall_head: got wen=%b wadd=%0d want 1/7", bus.GRFwen, bus.wadd); end
        advance();
        settle();
        nchecks++; if (bus.stall_req !== 1'b0 || bus.GRFwen !== 1'b0) begin nerr++; $display("FAIL stall_clear: got stall=%b wen=%b want 0/0", bus.stall_req, bus.GRFwen); end
        advance();
    endtask

    task automatic test_full();
        idle_inputs();
        bus.p_wen = 1; bus.p_wadd = 5'd2;
        for (int i = 0; i < 2; i++) begin
            bus.a_valid = 1; bus.a_wadd = 5'(10 + i); bus.a_wdat = 32'(16'hF0 + i);
            settle();
            nchecks++; if (bus.a_ready !== 1'b1) begin nerr++; $display("FAIL full_push%0d: got ready=%b want 1", i, bus.a_ready); end
            advance();
        end
        bus.a_wadd = 5'd12; bus.a_wdat = 32'hF2;
        for (int i = 0; i < 2; i++) begin
            settle();
            nchecks++; if (bus.a_ready !== 1'b0) begin nerr++; $display("FAIL full_ready%0d: got %b want 0", i, bus.a_ready); end
            advance();
        end
        bus.p_wen = 0;
        settle();
        nchecks++; if (bus.wadd !== 5'd10 || bus.a_ready !== 1'b0) begin nerr++; $display("FAIL full_pop10: got wadd=%0d ready=%b want 10/0", bus.wadd, bus.a_ready); end
        advance();
        settle();
        nchecks++; if (bus.wadd !== 5'd11 || bus.a_ready !== 1'b1) begin nerr++; $display("FAIL full_pop11: got wadd=%0d ready=%b want 11/1", bus.wadd, bus.a_ready); end
        advance();
        bus.a_valid = 0;
        settle();
        nchecks++; if (bus.wadd !== 5'd12 || bus.wdat !== 32'hF2) begin nerr++; $display("FAIL full_pop12: got %0d/%h want 12/f2", bus.wadd, bus.wdat); end
        advance();
    endtask

    task automatic test_drop();
        idle_inputs();
        bus.a_valid = 1; bus.a_wadd = 5'd4; bus.a_wdat = 32'h44;
        settle();
        advance();
        bus.a_valid = 0;
        bus.p_wen = 1; bus.p_wadd = 5'd1;
        repeat (3) begin settle(); advance(); end
        bus.p_wadd = 5'd3; bus.p_wdat = 32'h33;
        settle();
        nchecks++; if (bus.stall_req !== 1'b1 || bus.wadd !== 5'd4) begin nerr++; $display("FAIL drop_grant: got stall=%b wadd=%0d want 1/4", bus.stall_req, bus.wadd); end
        advance();
        idle_inputs();
        repeat (3) begin
            settle();
            nchecks++; if (bus.err_drop !== 1'b1) begin nerr++; $display("FAIL drop_sticky: got %b want 1", bus.err_drop); end
            nchecks++; if (bus.GRFwen !== 1'b0) begin nerr++; $display("FAIL drop_nowrite: got wen=%b wadd=%0d want 0", bus.GRFwen, bus.wadd); end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        bus.p_wen = 1; bus.p_wadd = 5'd1;
        bus.radd1 = 5'd20; bus.radd2 = 5'd21;
        for (int i = 0; i < 2; i++) begin
            bus.a_valid = 1; bus.a_wadd = 5'(20 + i);
            settle(); advance();
        end
        bus.a_valid = 0;
        settle();
        nchecks++; if (bus.hit1 !== 1'b1 || bus.hit2 !== 1'b1) begin nerr++; $display("FAIL rstmid_hits_pre: got %b%b want 11", bus.hit1, bus.hit2); end
        rst = 1'b1;
        settle();
        nchecks++; if (bus.GRFwen !== 1'b0 || bus.a_ready !== 1'b0) begin nerr++; $display("FAIL rstmid_during: got wen=%b ready=%b want 0/0", bus.GRFwen, bus.a_ready); end
        advance();
        rst = 1'b0;
        bus.p_wen = 0;
        settle();
        nchecks++; if (bus.hit1 !== 1'b0 || bus.hit2 !== 1'b0) begin nerr++; $display("FAIL rstmid_hits: got %b%b want 00", bus.hit1, bus.hit2); end
        nchecks++; if (bus.stall_req !== 1'b0 || bus.err_drop !== 1'b0 || bus.a_ready !== 1'b1) begin
            nerr++; $display("FAIL rstmid_state: got stall=%b err=%b ready=%b want 0/0/1", bus.stall_req, bus.err_drop, bus.a_ready); end
        for (int i = 0; i < 4; i++) begin
            nchecks++; if (bus.GRFwen !== 1'b0) begin nerr++; $display("FAIL rstmid_stale%0d: got wen=%b wadd=%0d want 0", i, bus.GRFwen, bus.wadd); end
            advance();
            settle();
        end
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 149) == 0);
            bus.p_wen   = ($urandom_range(0, 1) == 1);
            bus.p_wadd  = 5'($urandom_range(0, 7));
            bus.p_wdat  = $urandom;
            bus.p_wpc   = $urandom;
            bus.a_valid = ($urandom_range(0, 2) == 0);
            bus.a_wadd  = 5'($urandom_range(0, 7));
            bus.a_wdat  = $urandom;
            bus.a_wpc   = $urandom;
            bus.radd1   = 5'($urandom_range(0, 7));
            bus.radd2   = 5'($urandom_range(0, 7));
            settle();
            nchecks++; if (bus.a_ready !== exp_ready) begin nerr++; $display("FAIL rnd_ready @%0d: got %b want %b", n, bus.a_ready, exp_ready); end
            nchecks++; if (bus.stall_req !== m_stall) begin nerr++; $display("FAIL rnd_stall @%0d: got %b want %b", n, bus.stall_req, m_stall); end
            nchecks++; if (bus.err_drop !== m_err) begin nerr++; $display("FAIL rnd_err @%0d: got %b want %b", n, bus.err_drop, m_err); end
            nchecks++; if (bus.GRFwen !== exp_wen) begin nerr++; $display("FAIL rnd_wen @%0d: got %b want %b", n, bus.GRFwen, exp_wen); end
            nchecks++; if (bus.wadd !== exp_wadd) begin nerr++; $display("FAIL rnd_wadd @%0d: got %0d want %0d", n, bus.wadd, exp_wadd); end
            nchecks++; if (bus.wdat !== exp_wdat) begin nerr++; $display("FAIL rnd_wdat @%0d: got %h want %h", n, bus.wdat, exp_wdat); end
            nchecks++; if (bus.wpc !== exp_wpc) begin nerr++; $display("FAIL rnd_wpc @%0d: got %h want %h", n, bus.wpc, exp_wpc); end
            nchecks++; if (bus.hit1 !== exp_hit1) begin nerr++; $display("FAIL rnd_hit1 @%0d: got %b want %b", n, bus.hit1, exp_hit1); end
            nchecks++; if (bus.hit2 !== exp_hit2) begin nerr++; $display("FAIL rnd_hit2 @%0d: got %b want %b", n, bus.hit2, exp_hit2); end
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_age = 0; m_stall = 0; m_err = 0;
        test_reset();
        test_pipe_write();
        test_async_write();
        test_stall();
        test_full();
        test_drop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
